// File: rtl/prio_rr_arbiter.sv
// Fixed-priority / round-robin arbiter with a bounded grant length.
// One GAP cycle and one IDLE arbitration cycle separate consecutive grants.
module prio_rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      hold_q, hold_d;
    logic            to_q, to_d;

    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            found;
    logic            rel;
    logic            at_max;

    // First requester at or after the search start, wrapping at N-1.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = mode ? IW'((int'(ptr_q) + i) % N) : IW'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign rel    = done[id_q] | ~req[id_q];
    assign at_max = (hold_q == 8'(HOLD_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   if (rel || at_max) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        hold_d = hold_q;
        to_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    id_d       = win;
                    hold_d     = 8'd1;
                end
            end
            GRANT: begin
                if (rel || at_max) begin
                    // ptr only matters at the next IDLE, so it can move now.
                    gnt_d  = '0;
                    id_d   = '0;
                    hold_d = '0;
                    to_d   = at_max & ~done[id_q];
                    ptr_d  = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q  <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            to_q   <= to_d;
        end
    end

    always_comb begin
        gnt         = gnt_q;
        gnt_id      = id_q;
        busy        = (state_q == GRANT);
        timeout_err = to_q;
    end
endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_MAX, default 8: maximum grant length in cycles; legal range 2..255.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port mode, input, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 Port req, input, N: per-requester request level; held high until granted and done.
REQ-007 Port done, input, N: per-requester single-cycle release strobe.
REQ-008 Port gnt, output, N: registered grant; one-hot or zero.
REQ-009 Port gnt_id, output, clog2(N): index of the current holder; 0 when no grant is active.
REQ-010 Port busy, output, 1: high while state is GRANT.
REQ-011 Port timeout_err, output, 1: one-cycle pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, GRANT, GAP.
REQ-013 IDLE: if req != 0, select a winner, go to GRANT, and assert gnt on the next edge (req-to-gnt latency is 1 cycle).
REQ-014 IDLE with req == 0: stay in IDLE; gnt = 0.
REQ-015 Fixed mode: the winner SHALL be the lowest set index of req.
REQ-016 Round-robin mode: the winner SHALL be the first set bit of req searching upward from ptr, wrapping from N-1 to 0.
REQ-017 mode SHALL be sampled only in IDLE; a change during GRANT or GAP takes effect at the next arbitration.
REQ-018 GRANT: gnt SHALL stay constant, and the hold counter SHALL increment from 1 each cycle.
REQ-019 GRANT exit SHALL occur on the first of:
- done[gnt_id] = 1
- req[gnt_id] = 0
- hold counter = HOLD_MAX
Exit goes to GAP, with gnt = 0 on the following edge.
REQ-020 Exit by HOLD_MAX with no done in the same cycle SHALL pulse timeout_err for exactly one cycle, coincident with the GAP cycle.
REQ-021 Simultaneous done[gnt_id] and hold counter = HOLD_MAX: treat as a normal release; no timeout_err.
REQ-022 done bits of non-holders SHALL be ignored in all states; done in IDLE or GAP SHALL be ignored.
REQ-023 GAP: lasts exactly 1 cycle with gnt = 0; ptr <= (gnt_id + 1) mod N in both modes; then go to IDLE.
REQ-024 Back-to-back requests: minimum spacing between two grants is 1 GAP cycle plus 1 IDLE arbitration cycle.
REQ-025 gnt SHALL never have more than one bit set; gnt_id SHALL equal the index of the set bit whenever gnt != 0.

Reset
REQ-026 Asserting rst in any state SHALL immediately force:
- state = IDLE, ptr = 0, hold counter = 0
- gnt = 0, gnt_id = 0, busy = 0, timeout_err = 0
REQ-027 After rst deasserts, the first arbitration SHALL occur on the first rising edge with req != 0; a grant in progress at reset is lost and not resumed.

Verification
REQ-028 Fixed priority: mode=0, req=4'b1010 -> gnt=4'b0010 one cycle later, gnt_id=1; done[1] pulse -> GAP, then gnt=4'b1000.
REQ-029 Round-robin fairness: mode=1, req=4'b1111 held, done pulsed 2 cycles after each grant -> grant order 0,1,2,3,0.
REQ-030 Timeout: HOLD_MAX=8, req[2] held, no done -> gnt[2] high for exactly 8 cycles; timeout_err high for 1 cycle; then re-granted to 2 after GAP+IDLE.
REQ-031 Release by req drop: holder 3 deasserts req[3] without done -> gnt=0 next edge, timeout_err=0, ptr=0.
REQ-032 Reset mid-grant: rst asserted while gnt=4'b0100 -> gnt=0 and busy=0 before the next clock edge; with req=4'b0100 still high, gnt=4'b0100 one cycle after rst release.
REQ-033 Stray done and mode switch: done[0] while holder is 1 -> no effect; mode toggled during GRANT -> the new mode is used only at the next IDLE arbitration.
